if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction fetch/decode boundary stage. It takes the program counter from the PC stage, tags the synchronous instruction-memory read in flight, and holds the IF/ID instruction register that decode consumes. It also provides a one-entry skid buffer so that a stall never loses a fetched instruction, flush handling for taken Br/Jmp/JAL, and a 16-bit scan chain over the instruction register.

## Interface
Parameters:
- `DW`, default 16: instruction and address width.
- `NOP`, default 16'h0000: instruction word injected as a bubble.

Ports:
- `clk` in, 1: system clock. One clock domain.
- `reset` in, 1: synchronous, active-high reset.
- `pc_in` in, DW: current PC, driven from the PC stage's PC_out.
- `imem_addr` out, DW: instruction memory address. Equals `pc_in` combinationally.
- `imem_data` in, DW: instruction memory read data, valid one cycle after the address edge.
- `stall` in, 1: hazard stall. The same signal also holds the PC.
- `flush` in, 1: taken Br/Jmp/JAL. Kills wrong-path fetches.
- `ir_out` out, DW: IF/ID instruction.
- `ir_pc` out, DW: address of `ir_out`.
- `ir_pc_plus1` out, DW: `ir_pc + 1`, the JAL link value.
- `ir_valid` out, 1: `ir_out` is a real instruction, not a bubble.
- `scan_en` in, 1: 1 captures `ir_out` into the scan register; 0 shifts.
- `scan_in` in, 1: scan serial input.
- `scan_out` out, 1: scan register MSB.

## Operation
State:
- Fetch tag: `f_valid` and `f_pc`.
- Skid entry: `s_valid`, `s_data`, `s_pc`.
- IR: `ir_out`, `ir_pc`, `ir_valid`.
- Scan register: `Q[DW-1:0]`.

Per rising edge, in priority order:
- **reset:** `ir_out` ← NOP, `ir_pc` ← 0, `ir_valid` ← 0, `f_valid` ← 0, `f_pc` ← 0, `s_valid` ← 0.
- **flush** (wins over stall):
  - `ir_out` ← NOP, `ir_valid` ← 0.
  - `s_valid` ← 0, `f_valid` ← 0; the in-flight read is wrong-path.
  - `f_pc` ← `pc_in`.
- **stall:**
  - IR holds; `f_valid` and `f_pc` hold.
  - If `!s_valid && f_valid`: `s_data` ← `imem_data`, `s_pc` ← `f_pc`, `s_valid` ← 1.
  - Otherwise the skid entry holds. The `imem_data` seen on later stall cycles is a re-read of `pc_in` and is discarded.
- **advance:**
  - If `s_valid`: IR ← {`s_data`, `s_pc`, 1}.
  - Else if `f_valid`: IR ← {`imem_data`, `f_pc`, 1}.
  - Else: IR ← {NOP, `ir_pc`, 0}.
  - Then `s_valid` ← 0, `f_valid` ← 1, `f_pc` ← `pc_in`.

Combinational outputs:
- `ir_pc_plus1` = `ir_pc + 1`, modulo 2^DW (16'hFFFF → 16'h0000).
- `imem_addr` = `pc_in`, with no register.

Scan register:
- Independent of `reset`, `stall` and `flush`.
- `scan_en` = 1: `Q` ← `ir_out`.
- `scan_en` = 0: `Q` ← {`Q[DW-2:0]`, `scan_in`}.
- `scan_out` = `Q[DW-1]`.
- `Q` is not reset. Its value is undefined until the first capture.

## Timing
- Reset values: `ir_out` = NOP, `ir_pc` = 0, `ir_pc_plus1` = 1, `ir_valid` = 0.
- Fetch latency: PC value A is presented in cycle N, so `ir_out` = mem[A] with `ir_valid` = 1 in cycle N+2.
  - After reset is released, the first valid IR (pc = 0) appears on the second edge.
- Stall of k cycles: IR frozen for exactly k cycles.
  - On the first non-stall edge, IR takes the skid entry.
  - The next instruction follows on the edge after that.
  - No instruction is lost or duplicated.
- Flush: a flush edge followed by one further bubble edge.
  - The target instruction appears with `ir_valid` = 1 in the second cycle after the flush edge.
- `stall` and `flush` asserted together: flush behaviour; the skid entry is discarded.
- Reset mid-stall with a full skid entry: everything clears on the same edge; the skid entry is discarded.

## Structure
- Shared package `inst_pkg`: `INST_W` = 16, `NOP_INSTR` = 16'h0000, and a typedef for the {data, pc, valid} entry used by both the skid entry and the IR.
- One sub-module, `scan_shift16`: a capture/shift scan register with ports `clk`, `scan_en`, `scan_in`, `par_in[15:0]`, `scan_out`. It is reusable by the PC stage.

## Test plan
- **Reset then run:** mem[0..3] = 16'h1111/2222/3333/4444, `pc_in` incrementing from 0. Required: `ir_out` = 16'h1111, `ir_pc` = 0, `ir_valid` = 1 on the second edge after reset release; then one word per cycle in order.
- **Three-cycle stall:** stall asserted with pc 2 in flight. Required: IR holds 16'h2222 for three cycles, then shows 16'h3333 (`ir_pc` = 2), then 16'h4444.
- **Flush:** taken branch to 16'h0040, mem[0x40] = 16'hABCD. Required: two cycles with `ir_valid` = 0 and `ir_out` = NOP, then `ir_out` = 16'hABCD, `ir_pc` = 16'h0040, `ir_pc_plus1` = 16'h0041.
- **Stall and flush in the same cycle with a full skid entry:** required: skid contents never reach the IR; the behaviour matches the flush scenario.
- **Wrap:** `ir_pc` = 16'hFFFF. Required: `ir_pc_plus1` = 16'h0000. Also: reset asserted mid-stall gives `ir_valid` = 0 on the next edge.
- **Scan:** `ir_out` = 16'h8001. Capture with `scan_en` = 1, then 16 shift cycles with `scan_in` = 0. Required: `scan_out` sequence 1, 0 (×14), 1.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared instruction-path definitions for the fetch/decode boundary and the PC stage.
package inst_pkg;

  localparam int INST_W = 16;
  localparam logic [INST_W-1:0] NOP_INSTR = 16'h0000;

  // {data, pc, valid}: one fetched instruction together with its address.
  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [INST_W-1:0] pc;
    logic              valid;
  } ir_entry_t;

endpackage

// File: rtl/scan_shift16.sv
// 16-bit capture/shift scan register, MSB first out. Unreset by design.
module scan_shift16 (
  input  logic        clk,
  input  logic        scan_en,
  input  logic        scan_in,
  input  logic [15:0] par_in,
  output logic        scan_out
);

  logic [15:0] q;

  always_ff @(posedge clk) begin
    if (scan_en) q <= par_in;
    else         q <= {q[14:0], scan_in};
  end

  assign scan_out = q[15];

endmodule

// File: rtl/if_id_stage.sv
// IF/ID boundary: tags the synchronous imem read, holds the decode IR, and keeps a
// one-entry skid so a stall never drops the read that was in flight. DW must equal INST_W.
module if_id_stage
  import inst_pkg::*;
#(
  parameter int              DW  = 16,
  parameter logic [DW-1:0]   NOP = NOP_INSTR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] pc_in,
  output logic [DW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] ir_out,
  output logic [DW-1:0] ir_pc,
  output logic [DW-1:0] ir_pc_plus1,
  output logic          ir_valid,
  input  logic          scan_en,
  input  logic          scan_in,
  output logic          scan_out
);

  ir_entry_t     ir_q;
  ir_entry_t     skid_q;
  logic          f_valid;
  logic [DW-1:0] f_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q         <= '{data: NOP, pc: '0, valid: 1'b0};
      skid_q.valid <= 1'b0;
      f_valid      <= 1'b0;
      f_pc         <= '0;
    end else if (flush) begin
      // Read in flight is wrong-path; the target PC is fetched on the next edge.
      ir_q.data    <= NOP;
      ir_q.valid   <= 1'b0;
      skid_q.valid <= 1'b0;
      f_valid      <= 1'b0;
      f_pc         <= pc_in;
    end else if (stall) begin
      // Only the first stall cycle carries the real read; later ones re-read pc_in.
      if (!skid_q.valid && f_valid)
        skid_q <= '{data: imem_data, pc: f_pc, valid: 1'b1};
    end else begin
      if (skid_q.valid)
        ir_q <= skid_q;
      else if (f_valid)
        ir_q <= '{data: imem_data, pc: f_pc, valid: 1'b1};
      else begin
        ir_q.data  <= NOP;
        ir_q.valid <= 1'b0;
      end
      skid_q.valid <= 1'b0;
      f_valid      <= 1'b1;
      f_pc         <= pc_in;
    end
  end

  assign imem_addr   = pc_in;
  assign ir_out      = ir_q.data;
  assign ir_pc       = ir_q.pc;
  assign ir_valid    = ir_q.valid;
  assign ir_pc_plus1 = ir_q.pc + DW'(1);

  scan_shift16 u_scan (
    .clk      (clk),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .par_in   (ir_q.data),
    .scan_out (scan_out)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: static memory, PC stage emulated here, one-pending-fetch reference model.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic        scan_en = 1'b0, scan_in = 1'b0, scan_out, ir_valid;
  logic [15:0] pc_in = 16'h0, imem_addr, imem_data, ir_out, ir_pc, ir_pc_plus1;

  logic [15:0] mem [0:65535];
  int errors = 0, checks = 0;

  // Reference model: the visible IR plus at most one fetched-but-undelivered address.
  logic [15:0] m_ir = 16'h0, m_pc = 16'h0;
  logic        m_v = 1'b0, m_pend = 1'b0;
  logic [15:0] m_pend_pc = 16'h0;

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= mem[imem_addr];

  if_id_stage #(.DW(16), .NOP(16'h0000)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .flush(flush), .ir_out(ir_out), .ir_pc(ir_pc), .ir_pc_plus1(ir_pc_plus1),
    .ir_valid(ir_valid), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out)
  );

  task automatic step(input logic st, input logic fl, input logic [15:0] tgt, input logic rst);
    logic [15:0] pc_cur;
    pc_cur = pc_in;
    stall = st; flush = fl; reset = rst;
    @(posedge clk); #1;
    if (rst) begin
      m_ir = 16'h0; m_pc = 16'h0; m_v = 1'b0; m_pend = 1'b0;
    end else if (fl) begin
      m_ir = 16'h0; m_v = 1'b0; m_pend = 1'b0;
    end else if (!st) begin
      if (m_pend) begin m_ir = mem[m_pend_pc]; m_pc = m_pend_pc; m_v = 1'b1; end
      else begin m_ir = 16'h0; m_v = 1'b0; end
      m_pend = 1'b1; m_pend_pc = pc_cur;
    end
    pc_in = rst ? 16'h0 : fl ? tgt : st ? pc_in : pc_in + 16'd1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    checks++; if (ir_out !== 16'h0000) begin errors++; $display("FAIL reset_ir_out got=%h want=0000", ir_out); end
    checks++; if (ir_pc !== 16'h0000) begin errors++; $display("FAIL reset_ir_pc got=%h want=0000", ir_pc); end
    checks++; if (ir_pc_plus1 !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus1 got=%h want=0001", ir_pc_plus1); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ir_valid); end
  endtask

  task automatic test_run;
    logic [15:0] e_ir [3] = '{16'h0000, 16'h1111, 16'h2222};
    logic [15:0] e_pc [3] = '{16'h0000, 16'h0000, 16'h0001};
    logic        e_v  [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if ({ir_out, ir_pc, ir_valid} !== {e_ir[i], e_pc[i], e_v[i]} ||
          {ir_out, ir_pc, ir_valid} !== {m_ir, m_pc, m_v}) begin
        errors++;
        $display("FAIL run edge%0d got ir=%h pc=%h v=%b want ir=%h pc=%h v=%b", i + 1,
                 ir_out, ir_pc, ir_valid, e_ir[i], e_pc[i], e_v[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [15:0] e_ir [5] = '{16'h2222, 16'h2222, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] e_pc [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0003};
    for (int i = 0; i < 5; i++) begin
      step(i < 3, 1'b0, 16'h0, 1'b0);
      checks++;
      if ({ir_out, ir_pc, ir_valid} !== {e_ir[i], e_pc[i], 1'b1} || imem_addr !== pc_in) begin
        errors++;
        $display("FAIL stall edge%0d got ir=%h pc=%h v=%b addr=%h want ir=%h pc=%h v=1 addr=%h", i,
                 ir_out, ir_pc, ir_valid, imem_addr, e_ir[i], e_pc[i], pc_in);
      end
    end
  endtask

  task automatic test_flush;
    step(1'b0, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (i < 2 ? ({ir_out, ir_valid} !== {16'h0000, 1'b0})
                : ({ir_out, ir_pc, ir_pc_plus1, ir_valid} !== {16'hABCD, 16'h0040, 16'h0041, 1'b1})) begin
        errors++;
        $display("FAIL flush cyc%0d got ir=%h pc=%h p1=%h v=%b", i, ir_out, ir_pc, ir_pc_plus1, ir_valid);
      end
    end
  endtask

  task automatic test_stall_flush;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0040, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if (i < 2 ? ({ir_out, ir_valid} !== {16'h0000, 1'b0})
                : ({ir_out, ir_pc, ir_pc_plus1, ir_valid} !== {16'hABCD, 16'h0040, 16'h0041, 1'b1})) begin
        errors++;
        $display("FAIL stall_flush cyc%0d got ir=%h pc=%h p1=%h v=%b", i, ir_out, ir_pc, ir_pc_plus1, ir_valid);
      end
    end
  endtask

  task automatic test_wrap;
    step(1'b0, 1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if ({ir_out, ir_pc, ir_pc_plus1, ir_valid} !== {mem[16'hFFFF], 16'hFFFF, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL wrap got ir=%h pc=%h p1=%h v=%b want ir=%h pc=ffff p1=0000 v=1",
               ir_out, ir_pc, ir_pc_plus1, ir_valid, mem[16'hFFFF]);
    end
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if ({ir_out, ir_pc, ir_valid} !== {mem[16'h0000], 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL wrap_next got ir=%h pc=%h v=%b want ir=%h pc=0000 v=1", ir_out, ir_pc, ir_valid, mem[0]);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if ({ir_out, ir_pc, ir_valid} !== {16'h0000, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_stall got ir=%h pc=%h v=%b want ir=0000 pc=0000 v=0", ir_out, ir_pc, ir_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 16'h0, 1'b0);
      checks++;
      if ({ir_out, ir_pc, ir_valid} !== {m_ir, m_pc, m_v}) begin
        errors++;
        $display("FAIL after_reset cyc%0d got ir=%h pc=%h v=%b want ir=%h pc=%h v=%b", i,
                 ir_out, ir_pc, ir_valid, m_ir, m_pc, m_v);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 30, $urandom_range(99) < 10, 16'($urandom), $urandom_range(99) < 2);
      checks++;
      if ({ir_out, ir_pc, ir_valid, ir_pc_plus1, imem_addr} !== {m_ir, m_pc, m_v, m_pc + 16'd1, pc_in}) begin
        errors++;
        $display("FAIL random cyc%0d got ir=%h pc=%h v=%b p1=%h addr=%h want ir=%h pc=%h v=%b p1=%h addr=%h", i,
                 ir_out, ir_pc, ir_valid, ir_pc_plus1, imem_addr, m_ir, m_pc, m_v, m_pc + 16'd1, pc_in);
      end
    end
  endtask

  task automatic test_scan;
    logic [15:0] par;
    logic        e_bit;
    par = 16'h8001;
    step(1'b0, 1'b1, 16'h0080, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    checks++;
    if (ir_out !== par) begin errors++; $display("FAIL scan_setup got ir=%h want=%h", ir_out, par); end
    scan_en = 1'b1; scan_in = 1'b0;
    step(1'b1, 1'b0, 16'h0, 1'b0);
    scan_en = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step(1'b1, 1'b0, 16'h0, 1'b0);
      e_bit = (k < 16) ? par[15 - k] : 1'b0;
      checks++;
      if (scan_out !== e_bit) begin
        errors++;
        $display("FAIL scan shift%0d got=%b want=%b", k, scan_out, e_bit);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[16'h0040] = 16'hABCD; mem[16'h0080] = 16'h8001;
    test_reset;
    test_run;
    test_stall;
    test_flush;
    test_stall_flush;
    test_wrap;
    test_random;
    test_scan;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
